// File: rtl/sum_sq_m.sv
// ----------------------------------------------------------------------------
// sum_sq_m
// Iterative sum-of-squares unit: r = x*x + y*y, computed with a shift-add
// multiplier that reuses one accumulator for both squares. Feeds sqrt_m in
// the vector-magnitude path and shares its start/ready handshake.
//
// Parameters
//   DW     : operand width
//   SIGNED : 1 = x, y are two's complement; 0 = unsigned
//
// Ports
//   clk    in   1        clock, rising edge
//   rst    in   1        synchronous reset, active-high
//   start  in   1        request, sampled only while ready=1
//   x      in   DW       operand X, sampled on the accepting edge
//   y      in   DW       operand Y, sampled on the accepting edge
//   ready  out  1        1 = idle and r valid; 0 = busy
//   r      out  2*DW+1   result x*x + y*y, unsigned
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; r holds the last result
// SQX   | DW cycles accumulating |x| * |x|, one partial product per cycle
// SQY   | DW cycles accumulating |y| * |y| into the same accumulator
// ----------------------------------------------------------------------------
module sum_sq_m #(
    parameter int DW     = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   x,
    input  logic [DW-1:0]   y,
    output logic            ready,
    output logic [2*DW:0]   r
);

    localparam int AW = 2*DW + 1;
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQX  = 2'd1,
        SQY  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_opx;
    logic [DW-1:0]   r_opy;
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   r_res;

    logic [DW-1:0]   w_absx;
    logic [DW-1:0]   w_absy;
    logic [DW-1:0]   w_mcand;
    logic            w_bit;
    logic            w_last;
    logic [AW-1:0]   w_addend;
    logic [AW-1:0]   w_acc_nxt;

    // -2^(DW-1) negates to itself, which read as unsigned is exactly 2^(DW-1).
    function automatic logic [DW-1:0] f_abs(input logic [DW-1:0] v);
        if (SIGNED && v[DW-1]) begin
            return (~v) + DW'(1);
        end
        return v;
    endfunction

    assign w_absx = f_abs(x);
    assign w_absy = f_abs(y);

    always_comb begin
        w_mcand   = (r_state == SQY) ? r_opy : r_opx;
        w_bit     = w_mcand[r_cnt];
        w_addend  = w_bit ? (AW'(w_mcand) << r_cnt) : '0;
        w_acc_nxt = r_acc + w_addend;
        w_last    = (r_cnt == LAST);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = SQX;
            SQX:     if (w_last) w_state_nxt = SQY;
            SQY:     if (w_last) w_state_nxt = IDLE;
            default:             w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_opx <= '0;
            r_opy <= '0;
            r_acc <= '0;
            r_res <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_opx <= w_absx;
                        r_opy <= w_absy;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                SQX, SQY: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                    // The final partial product is folded in on the same edge
                    // that publishes the result.
                    if (r_state == SQY && w_last) begin
                        r_res <= w_acc_nxt;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign ready = (r_state == IDLE);
    assign r     = r_res;

endmodule

// File: tb/tb_sum_sq_m.sv
// ----------------------------------------------------------------------------
// tb_sum_sq_m
// Three instances run side by side on one clock: DW=8 unsigned, DW=8 signed
// and DW=4 unsigned. Expected results come from plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_sum_sq_m;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  xu, yu, xs, ys;
    logic [3:0]  x4, y4;
    logic        rdy_u, rdy_s, rdy_4;
    logic [16:0] r_u, r_s;
    logic [8:0]  r_4;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sum_sq_m #(.DW(8), .SIGNED(1'b0)) u_u8 (
        .clk(clk), .rst(rst), .start(start), .x(xu), .y(yu), .ready(rdy_u), .r(r_u));
    sum_sq_m #(.DW(8), .SIGNED(1'b1)) u_s8 (
        .clk(clk), .rst(rst), .start(start), .x(xs), .y(ys), .ready(rdy_s), .r(r_s));
    sum_sq_m #(.DW(4), .SIGNED(1'b0)) u_u4 (
        .clk(clk), .rst(rst), .start(start), .x(x4), .y(y4), .ready(rdy_4), .r(r_4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic scramble();
        xu = 8'($urandom); yu = 8'($urandom);
        xs = 8'($urandom); ys = 8'($urandom);
        x4 = 4'($urandom); y4 = 4'($urandom);
    endtask

    // One operation on all three instances; checks result, busy length and
    // that r stays put while busy. Operands are scrambled after acceptance.
    task automatic op(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d,
                      input logic [3:0] e, input logic [3:0] f);
        int eu, es, e4, sa, sb, lu, ls, l4;
        logic [16:0] pu, ps;
        logic [8:0]  p4;
        bit su, ss, s4, done;
        eu = int'(a) * int'(a) + int'(b) * int'(b);
        sa = int'($signed(c));
        sb = int'($signed(d));
        es = sa * sa + sb * sb;
        e4 = int'(e) * int'(e) + int'(f) * int'(f);
        @(negedge clk);
        xu = a; yu = b; xs = c; ys = d; x4 = e; y4 = f;
        start = 1'b1;
        pu = r_u; ps = r_s; p4 = r_4;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        lu = 0; ls = 0; l4 = 0;
        su = 1'b1; ss = 1'b1; s4 = 1'b1; done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!rdy_u) begin lu++; if (r_u !== pu) su = 1'b0; end
            if (!rdy_s) begin ls++; if (r_s !== ps) ss = 1'b0; end
            if (!rdy_4) begin l4++; if (r_4 !== p4) s4 = 1'b0; end
            scramble();
            if (rdy_u && rdy_s && rdy_4) begin
                done = 1'b1;
                break;
            end
        end
        chk("op_done", 32'(done), 32'd1);
        chk("lat_u8", 32'(lu), 32'd16);
        chk("lat_s8", 32'(ls), 32'd16);
        chk("lat_u4", 32'(l4), 32'd8);
        chk("r_u8", 32'(r_u), 32'(eu));
        chk("r_s8", 32'(r_s), 32'(es));
        chk("r_u4", 32'(r_4), 32'(e4));
        chk("busy_hold_u8", 32'(su), 32'd1);
        chk("busy_hold_s8", 32'(ss), 32'd1);
        chk("busy_hold_u4", 32'(s4), 32'd1);
    endtask

    initial begin
        int lastu, last4, pcu, pc4;
        bit done;
        rst = 1'b1; start = 1'b0;
        xu = '0; yu = '0; xs = '0; ys = '0; x4 = '0; y4 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready_u8", 32'(rdy_u), 32'd1);
        chk("rst_ready_s8", 32'(rdy_s), 32'd1);
        chk("rst_ready_u4", 32'(rdy_4), 32'd1);
        chk("rst_r_u8", 32'(r_u), 32'd0);
        chk("rst_r_s8", 32'(r_s), 32'd0);
        chk("rst_r_u4", 32'(r_4), 32'd0);

        // Directed corners
        op(8'd3,   8'd4,   8'h80, 8'h80, 4'd3,  4'd4);
        op(8'd255, 8'd255, 8'hFD, 8'd4,  4'd15, 4'd15);
        op(8'd0,   8'd0,   8'h7F, 8'h81, 4'd0,  4'd0);
        op(8'd1,   8'd128, 8'hFF, 8'h00, 4'd8,  4'd1);

        // Exhaustive DW=4 with random 8-bit operands alongside
        for (int i = 0; i < 256; i++) begin
            op(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               4'(i >> 4), 4'(i));
        end

        // Reset in the middle of an operation
        @(negedge clk);
        xu = 8'd200; yu = 8'd100; xs = 8'd200; ys = 8'd100; x4 = 4'd9; y4 = 4'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_busy_u8", 32'(rdy_u), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready_u8", 32'(rdy_u), 32'd1);
        chk("midrst_ready_s8", 32'(rdy_s), 32'd1);
        chk("midrst_ready_u4", 32'(rdy_4), 32'd1);
        chk("midrst_r_u8", 32'(r_u), 32'd0);
        chk("midrst_r_s8", 32'(r_s), 32'd0);
        chk("midrst_r_u4", 32'(r_4), 32'd0);
        op(8'd1, 8'd2, 8'd1, 8'd2, 4'd1, 4'd2);

        // start held high: back-to-back operations with 1-cycle ready pulses
        @(negedge clk);
        xu = 8'd1; yu = 8'd1; xs = 8'd1; ys = 8'd1; x4 = 4'd1; y4 = 4'd1;
        start = 1'b1;
        lastu = -1; last4 = -1; pcu = 0; pc4 = 0;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (rdy_u) begin
                chk("held_r_u8", 32'(r_u), 32'd2);
                chk("held_r_s8", 32'(r_s), 32'd2);
                if (lastu >= 0) chk("held_period_u8", 32'(k - lastu), 32'd17);
                lastu = k; pcu++;
                xu = 8'd1; yu = 8'd1; xs = 8'd1; ys = 8'd1;
            end else begin
                xu = 8'($urandom); yu = 8'($urandom);
                xs = 8'($urandom); ys = 8'($urandom);
            end
            if (rdy_4) begin
                chk("held_r_u4", 32'(r_4), 32'd2);
                if (last4 >= 0) chk("held_period_u4", 32'(k - last4), 32'd9);
                last4 = k; pc4++;
                x4 = 4'd1; y4 = 4'd1;
            end else begin
                x4 = 4'($urandom); y4 = 4'($urandom);
            end
        end
        start = 1'b0;
        chk("held_pulses_u8", 32'(pcu >= 4), 32'd1);
        chk("held_pulses_u4", 32'(pc4 >= 8), 32'd1);
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rdy_u && rdy_s && rdy_4) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", 32'(done), 32'd1);
        chk("drain_r_u8", 32'(r_u), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
